// File: rtl/fetch_pc_gen_if.sv
// Fetch PC generator bus: control inputs from the pipeline and the
// fetch request/address outputs towards instruction memory.
interface fetch_pc_gen_if #(
   parameter int XLEN    = 32,
   parameter int EPOCH_W = 2
);
   logic               enable;
   logic               redirect_valid;
   logic [XLEN-1:0]    redirect_pc;
   logic               trap_valid;
   logic [XLEN-1:0]    trap_vec;
   logic               pred_taken;
   logic [XLEN-1:0]    pred_target;
   logic               req_ready;
   logic               req_valid;
   logic [XLEN-1:0]    pc;
   logic [XLEN-1:0]    next_pc;
   logic [EPOCH_W-1:0] epoch;
   logic               misalign_err;

   // The PC generator drives the fetch request side.
   modport master (
      input  enable, redirect_valid, redirect_pc, trap_valid, trap_vec,
             pred_taken, pred_target, req_ready,
      output req_valid, pc, next_pc, epoch, misalign_err
   );

   // The pipeline / memory side that feeds the generator.
   modport slave (
      output enable, redirect_valid, redirect_pc, trap_valid, trap_vec,
             pred_taken, pred_target, req_ready,
      input  req_valid, pc, next_pc, epoch, misalign_err
   );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: BOOT/RUN/ERR FSM selecting the next fetch address
// from trap, redirect, branch prediction or sequential increment, with a
// redirect epoch tag and misaligned-redirect error tracking.
module fetch_pc_gen #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = {XLEN{1'b0}},
   parameter int              STEP      = 4,
   parameter int              EPOCH_W   = 2
) (
   input logic              clk,
   input logic              reset,
   fetch_pc_gen_if.master   bus
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [XLEN-1:0]    r_pc;
   logic [XLEN-1:0]    w_pc_nxt;
   logic [EPOCH_W-1:0] r_epoch;
   logic [EPOCH_W-1:0] w_epoch_nxt;
   logic               r_err;
   logic               w_err_nxt;
   logic               w_req_valid;
   logic               w_handshake;
   logic [XLEN-1:0]    w_next_pc;
   logic [EPOCH_W-1:0] w_epoch_inc;

   // Alignment check on the two low address bits; 2-byte steps only
   // require halfword alignment.
   function automatic logic f_misaligned(input logic [1:0] low_bits);
      logic res;
      if (STEP == 4) begin
         res = (low_bits != 2'b00);
      end else begin
         res = low_bits[0];
      end
      return res;
   endfunction

   assign w_next_pc   = r_pc + XLEN'(STEP);
   assign w_epoch_inc = r_epoch + EPOCH_W'(1);
   assign w_req_valid = (r_state == ST_RUN) && bus.enable;
   assign w_handshake = w_req_valid && bus.req_ready;

   // Next-state and next-PC selection, trap first, then redirect, then fetch.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_epoch_nxt = r_epoch;
      w_err_nxt   = r_err;
      if (bus.trap_valid) begin
         // Traps are honoured in every state and recover from ERR.
         w_pc_nxt    = bus.trap_vec;
         w_epoch_nxt = w_epoch_inc;
         w_err_nxt   = 1'b0;
         w_state_nxt = ST_RUN;
      end else begin
         case (r_state)
            ST_BOOT: begin
               if (bus.enable) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt = ST_BOOT;
               end
            end
            ST_RUN: begin
               if (bus.redirect_valid) begin
                  if (f_misaligned(bus.redirect_pc[1:0])) begin
                     // Bad target: keep pc, flag it, stop fetching until a trap.
                     w_err_nxt   = 1'b1;
                     w_state_nxt = ST_ERR;
                  end else begin
                     w_pc_nxt    = bus.redirect_pc;
                     w_epoch_nxt = w_epoch_inc;
                  end
               end else if (w_handshake) begin
                  if (bus.pred_taken && !f_misaligned(bus.pred_target[1:0])) begin
                     w_pc_nxt = bus.pred_target;
                  end else begin
                     // A misaligned prediction is simply not trusted.
                     w_pc_nxt = w_next_pc;
                  end
               end else begin
                  w_pc_nxt = r_pc;
               end
            end
            ST_ERR: begin
               w_state_nxt = ST_ERR;
            end
            default: begin
               w_state_nxt = ST_BOOT;
            end
         endcase
      end
   end

   // State, PC, epoch and error registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_BOOT;
         r_pc    <= RESET_VEC;
         r_epoch <= {EPOCH_W{1'b0}};
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_epoch <= w_epoch_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign bus.req_valid    = w_req_valid;
   assign bus.pc           = r_pc;
   assign bus.next_pc      = w_next_pc;
   assign bus.epoch        = r_epoch;
   assign bus.misalign_err = r_err;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen (XLEN=32, STEP=4, EPOCH_W=2).
module tb_fetch_pc_gen;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   fetch_pc_gen_if #(.XLEN(32), .EPOCH_W(2)) bus ();

   fetch_pc_gen #(
      .XLEN(32), .RESET_VEC(32'h0000_0000), .STEP(4), .EPOCH_W(2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.enable = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.trap_valid = 1'b0;
      bus.trap_vec = 32'h0;
      bus.pred_taken = 1'b0;
      bus.pred_target = 32'h0;
      bus.req_ready = 1'b0;
      #12;
      chk("rst_pc", bus.pc, 32'h0);
      chk("rst_epoch", {30'h0, bus.epoch}, 32'h0);
      chk("rst_err", {31'h0, bus.misalign_err}, 32'h0);
      chk("rst_req_valid", {31'h0, bus.req_valid}, 32'h0);

      // Sequential fetch after reset
      reset = 1'b0;
      bus.enable = 1'b1;
      bus.req_ready = 1'b1;
      #1;
      chk("boot_no_req", {31'h0, bus.req_valid}, 32'h0);
      step();
      chk("seq_pc0", bus.pc, 32'h0);
      chk("seq_req_valid", {31'h0, bus.req_valid}, 32'h1);
      step();
      chk("seq_pc4", bus.pc, 32'h4);
      step();
      chk("seq_pc8", bus.pc, 32'h8);
      step();
      chk("seq_pc12", bus.pc, 32'hC);
      chk("seq_epoch", {30'h0, bus.epoch}, 32'h0);
      chk("seq_next_pc", bus.next_pc, 32'h10);
      step();
      chk("seq_pc16", bus.pc, 32'h10);

      // Stall without ready
      bus.req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_pc", bus.pc, 32'h10);
         chk("stall_req_valid", {31'h0, bus.req_valid}, 32'h1);
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h100;
      step();
      chk("redir_pc", bus.pc, 32'h100);
      chk("redir_epoch", {30'h0, bus.epoch}, 32'h1);

      // Misaligned redirect, then recovery by trap
      bus.redirect_pc = 32'h102;
      step();
      chk("mis_pc", bus.pc, 32'h100);
      chk("mis_err", {31'h0, bus.misalign_err}, 32'h1);
      chk("mis_req_valid", {31'h0, bus.req_valid}, 32'h0);
      chk("mis_epoch", {30'h0, bus.epoch}, 32'h1);
      bus.redirect_pc = 32'h200;
      step();
      chk("err_redir_ignored_pc", bus.pc, 32'h100);
      chk("err_sticky", {31'h0, bus.misalign_err}, 32'h1);
      chk("err_redir_epoch", {30'h0, bus.epoch}, 32'h1);
      bus.redirect_valid = 1'b0;
      bus.trap_valid = 1'b1;
      bus.trap_vec = 32'h80;
      step();
      chk("trap_pc", bus.pc, 32'h80);
      chk("trap_err_clr", {31'h0, bus.misalign_err}, 32'h0);
      chk("trap_run", {31'h0, bus.req_valid}, 32'h1);
      chk("trap_epoch", {30'h0, bus.epoch}, 32'h2);
      bus.trap_valid = 1'b0;
      bus.req_ready = 1'b1;
      step();
      chk("after_trap_pc", bus.pc, 32'h84);

      // Trap and redirect on the same edge
      bus.req_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h200;
      bus.trap_valid = 1'b1;
      bus.trap_vec = 32'h80;
      step();
      chk("both_pc", bus.pc, 32'h80);
      chk("both_epoch", {30'h0, bus.epoch}, 32'h3);
      bus.trap_valid = 1'b0;

      // Epoch wrap over four redirects
      bus.redirect_pc = 32'h300;
      step();
      chk("wrap_epoch0", {30'h0, bus.epoch}, 32'h0);
      chk("wrap_pc0", bus.pc, 32'h300);
      bus.redirect_pc = 32'h304;
      step();
      bus.redirect_pc = 32'h308;
      step();
      bus.redirect_pc = 32'h30C;
      step();
      chk("wrap_epoch3", {30'h0, bus.epoch}, 32'h3);
      chk("wrap_pc3", bus.pc, 32'h30C);
      bus.redirect_valid = 1'b0;

      // Branch prediction
      bus.req_ready = 1'b1;
      bus.pred_taken = 1'b1;
      bus.pred_target = 32'h40;
      step();
      chk("pred_pc", bus.pc, 32'h40);
      chk("pred_epoch", {30'h0, bus.epoch}, 32'h3);
      bus.pred_target = 32'h41;
      step();
      chk("pred_mis_pc", bus.pc, 32'h44);
      chk("pred_mis_err", {31'h0, bus.misalign_err}, 32'h0);
      bus.pred_taken = 1'b0;

      // Address wrap at the top of the space
      bus.req_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFC;
      step();
      chk("top_pc", bus.pc, 32'hFFFF_FFFC);
      chk("top_next_pc", bus.next_pc, 32'h0);
      chk("top_epoch", {30'h0, bus.epoch}, 32'h0);
      bus.redirect_valid = 1'b0;
      bus.req_ready = 1'b1;
      step();
      chk("wrap_to_zero", bus.pc, 32'h0);
      chk("wrap_no_err", {31'h0, bus.misalign_err}, 32'h0);

      // enable=0 in RUN holds pc and keeps the state
      bus.enable = 1'b0;
      #1;
      chk("dis_req_valid", {31'h0, bus.req_valid}, 32'h0);
      step();
      chk("dis_pc_hold", bus.pc, 32'h0);
      bus.enable = 1'b1;
      #1;
      chk("reen_req_valid", {31'h0, bus.req_valid}, 32'h1);
      step();
      chk("reen_pc", bus.pc, 32'h4);

      // Asynchronous reset between edges, mid-handshake
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_pc", bus.pc, 32'h0);
      chk("async_rst_epoch", {30'h0, bus.epoch}, 32'h0);
      chk("async_rst_req_valid", {31'h0, bus.req_valid}, 32'h0);
      step();
      chk("rst_hold_pc", bus.pc, 32'h0);
      reset = 1'b0;
      #1;
      chk("post_rst_no_req", {31'h0, bus.req_valid}, 32'h0);
      step();
      chk("post_rst_req", {31'h0, bus.req_valid}, 32'h1);
      chk("post_rst_pc", bus.pc, 32'h0);

      // Trap accepted from BOOT; redirect ignored in BOOT
      reset = 1'b1;
      #1;
      reset = 1'b0;
      bus.enable = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h102;
      step();
      chk("boot_redir_err", {31'h0, bus.misalign_err}, 32'h0);
      chk("boot_redir_pc", bus.pc, 32'h0);
      bus.redirect_valid = 1'b0;
      bus.trap_valid = 1'b1;
      bus.trap_vec = 32'h80;
      step();
      chk("boot_trap_pc", bus.pc, 32'h80);
      chk("boot_trap_epoch", {30'h0, bus.epoch}, 32'h1);
      bus.trap_valid = 1'b0;
      bus.enable = 1'b1;
      #1;
      chk("boot_trap_run", {31'h0, bus.req_valid}, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
